// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply/divide sequencer.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic [WIDTH-1:0] hi_cur;
  logic [WIDTH-1:0] lo_cur;
  logic             busy;
  logic             hilo_we;
  logic [WIDTH-1:0] hilo_hi;
  logic [WIDTH-1:0] hilo_lo;

  modport master (
    output start, op, a, b, flush, hi_cur, lo_cur,
    input  busy, hilo_we, hilo_hi, hilo_lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_cur, lo_cur,
    output busy, hilo_we, hilo_hi, hilo_lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: iterative shift-add multiply / restoring divide on magnitudes,
// sign fix-up, then a single write pulse into the HI/LO register.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_WB} state_t;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hilo_hi_q, hilo_hi_d;
  logic [WIDTH-1:0]   hilo_lo_q, hilo_lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;

  logic               op_valid, accept, signed_op, div_op, ge;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0] prod;

  assign op_valid  = (bus.op <= OP_MTLO);
  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign div_op    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign accept    = (state_q == S_IDLE) && bus.start && !bus.flush && op_valid;
  assign a_mag     = mag(bus.a, signed_op);
  assign b_mag     = mag(bus.b, signed_op);

  assign bus.busy    = (state_q != S_IDLE) || (bus.start && op_valid && !bus.flush);
  assign bus.hilo_we = (state_q == S_WB) && !bus.flush;
  assign bus.hilo_hi = hilo_hi_q;
  assign bus.hilo_lo = hilo_lo_q;

  // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign ge       = ~div_diff[WIDTH];
  assign prod     = neg2_if(acc_q, neg_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    hilo_hi_d = hilo_hi_q;
    hilo_lo_d = hilo_lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          neg_d     = signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          rem_neg_d = (bus.op == OP_DIV) && bus.a[WIDTH-1];
          is_div_d  = div_op;
          dz_d      = div_op && (bus.b == '0);
          a_raw_d   = bus.a;
          cnt_d     = '0;
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              acc_d   = {{WIDTH{1'b0}}, b_mag};
              opnd_d  = a_mag;
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              acc_d   = {{WIDTH{1'b0}}, a_mag};
              opnd_d  = b_mag;
              state_d = S_RUN;
            end
            OP_MTHI: begin
              hilo_hi_d = bus.a;
              hilo_lo_d = bus.lo_cur;
              state_d   = S_WB;
            end
            default: begin
              hilo_hi_d = bus.hi_cur;
              hilo_lo_d = bus.a;
              state_d   = S_WB;
            end
          endcase
        end
      end
      S_RUN: begin
        if (is_div_q)
          acc_d = {(ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
        else
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_div_q && dz_q) begin
          hilo_hi_d = a_raw_q;
          hilo_lo_d = '1;
        end else if (is_div_q) begin
          hilo_hi_d = neg_if(acc_q[2*WIDTH-1:WIDTH], rem_neg_q);
          hilo_lo_d = neg_if(acc_q[WIDTH-1:0], neg_q);
        end else begin
          hilo_hi_d = prod[2*WIDTH-1:WIDTH];
          hilo_lo_d = prod[WIDTH-1:0];
        end
        state_d = S_WB;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      hilo_hi_q <= '0;
      hilo_lo_q <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      hilo_hi_q <= hilo_hi_d;
      hilo_lo_q <= hilo_lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table for results/latency plus flush, rst and ignore cases.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.WIDTH(W)) bus();
  muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hic;
    logic [31:0] loc;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int checks = 0;
  int failures = 0;

  logic        r_busy0, r_busy_post, r_timeout;
  int          r_busy_cnt, r_we_cnt, r_we_cyc;
  logic [31:0] r_hi, r_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // poke_kind: 0 none, 1 flush, 2 start(MTHI) while busy, 3 rst; applied for one cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hic, input logic [31:0] loc,
                        input int poke_cyc, input int poke_kind);
    r_busy0 = 1'b0; r_busy_post = 1'bx; r_timeout = 1'b1;
    r_busy_cnt = 0; r_we_cnt = 0; r_we_cyc = -1; r_hi = 'x; r_lo = 'x;
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.hi_cur = hic; bus.lo_cur = loc; bus.start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == poke_cyc) begin
        case (poke_kind)
          1: bus.flush = 1'b1;
          2: begin bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD_BEEF; end
          3: rst = 1'b1;
          default: ;
        endcase
      end
      if (poke_kind != 0 && i == poke_cyc + 1) begin
        bus.flush = 1'b0; rst = 1'b0;
        if (poke_kind == 2) bus.start = 1'b0;
      end
      #1;
      if (i == 0) r_busy0 = bus.busy;
      else if (bus.busy) r_busy_cnt++;
      if (i == poke_cyc + 1) r_busy_post = bus.busy;
      if (bus.hilo_we) begin
        r_we_cnt++; r_we_cyc = i; r_hi = bus.hilo_hi; r_lo = bus.hilo_lo;
      end
      if (i > 0 && !bus.busy) begin
        r_timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (i == 0) begin
        bus.start = 1'b0; bus.hi_cur = 32'h0BAD_0BAD; bus.lo_cur = 32'h0BAD_0BAD;
      end
      @(negedge clk);
    end
    check("timeout", {31'd0, r_timeout}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{3'd3, 32'd100,       32'h0000_0000, 32'h0, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[5]  = '{3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd3, 32'd9,         32'd4,         32'h0, 32'h0, 32'h0000_0001, 32'h0000_0002};
    vecs[7]  = '{3'd4, 32'h0000_1234, 32'h0, 32'h0000_AAAA, 32'h0000_5678, 32'h0000_1234, 32'h0000_5678};
    vecs[8]  = '{3'd5, 32'h0000_0055, 32'h0, 32'h0000_0099, 32'h0000_7777, 32'h0000_0099, 32'h0000_0055};
    vecs[9]  = '{3'd0, 32'd7,         32'hFFFF_FFFA, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[10] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0000, 32'h0000_0001};
    vecs[11] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[12] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0, 32'h0, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[13] = '{3'd1, 32'h1234_5678, 32'h0000_0010, 32'h0, 32'h0, 32'h0000_0001, 32'h2345_6780};
    vecs[14] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h4000_0000, 32'h0000_0000};

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0;
    bus.a = '0; bus.b = '0; bus.hi_cur = '0; bus.lo_cur = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_we", {31'd0, bus.hilo_we}, 32'd0);
    check("rst_hi", bus.hilo_hi, 32'd0);
    check("rst_lo", bus.hilo_lo, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      int lat;
      lat = (vecs[i].op >= 3'd4) ? 1 : W + 2;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hic, vecs[i].loc, -1, 0);
      check($sformatf("v%0d_busy0", i), {31'd0, r_busy0}, 32'd1);
      check($sformatf("v%0d_busy_cycles", i), r_busy_cnt, lat);
      check($sformatf("v%0d_we_count", i), r_we_cnt, 1);
      check($sformatf("v%0d_we_cycle", i), r_we_cyc, lat);
      check($sformatf("v%0d_hi", i), r_hi, vecs[i].ehi);
      check($sformatf("v%0d_lo", i), r_lo, vecs[i].elo);
    end

    // Flush mid-multiply, then a clean divide.
    run_op(3'd1, 32'd7, 32'd6, 32'h0, 32'h0, 10, 1);
    check("flush_run_we", r_we_cnt, 0);
    check("flush_run_busy_next", {31'd0, r_busy_post}, 32'd0);
    run_op(3'd3, 32'd9, 32'd4, 32'h0, 32'h0, -1, 0);
    check("after_flush_we", r_we_cnt, 1);
    check("after_flush_lo", r_lo, 32'd2);
    check("after_flush_hi", r_hi, 32'd1);

    // Flush in the WB cycle masks the write pulse.
    run_op(3'd1, 32'd3, 32'd3, 32'h0, 32'h0, W + 2, 1);
    check("flush_wb_we", r_we_cnt, 0);
    check("flush_wb_busy_next", {31'd0, r_busy_post}, 32'd0);

    // Unused opcode is ignored.
    run_op(3'd6, 32'h1111_1111, 32'h0, 32'h0, 32'h0, -1, 0);
    check("op6_busy0", {31'd0, r_busy0}, 32'd0);
    check("op6_busy_cycles", r_busy_cnt, 0);
    check("op6_we", r_we_cnt, 0);

    // start while running is ignored.
    run_op(3'd1, 32'd3, 32'd3, 32'h0, 32'h0, 5, 2);
    check("start_in_run_we", r_we_cnt, 1);
    check("start_in_run_cycle", r_we_cyc, W + 2);
    check("start_in_run_hi", r_hi, 32'd0);
    check("start_in_run_lo", r_lo, 32'd9);

    // Flush together with start in IDLE: nothing accepted.
    @(negedge clk);
    bus.op = 3'd1; bus.a = 32'd2; bus.b = 32'd2; bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    check("flush_start_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy_after", {31'd0, bus.busy}, 32'd0);
    check("flush_start_we_after", {31'd0, bus.hilo_we}, 32'd0);

    // rst mid-run: idle next cycle, no write, result registers cleared.
    run_op(3'd3, 32'd100, 32'd7, 32'h0, 32'h0, 8, 3);
    check("rst_run_busy_next", {31'd0, r_busy_post}, 32'd0);
    check("rst_run_we", r_we_cnt, 0);
    check("rst_run_hi", bus.hilo_hi, 32'd0);
    check("rst_run_lo", bus.hilo_lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
